// File: rtl/text_console_if.sv
// ============================================================================
// Module : text_console_if
// Brief  : Byte-stream input and Wishbone write port of the text console.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface text_console_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        ack_i;

    // Console side: consumes the byte stream, initiates bus writes
    modport master (
        input  in_data, in_valid, ack_i,
        output in_ready, adr_o, dat_o, sel_o, we_o, stb_o
    );

    // Environment side: byte source and character-RAM target
    modport slave (
        output in_data, in_valid, ack_i,
        input  in_ready, adr_o, dat_o, sel_o, we_o, stb_o
    );
endinterface

`default_nettype wire

// File: rtl/text_console.sv
// ============================================================================
// Module : text_console
// Brief  : Byte stream to 80x60 character-RAM writer with cursor tracking,
//          control codes (LF, CR, BS, FF) and line/screen clearing.
//          Optional feature macro: CONSOLE_TAB_EN (0x09 advances to next tab
//          stop of 8 columns; undefined means 0x09 is ignored).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_console #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 60,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  wire              clk_25mhz,
    input  wire              rst_i,
    text_console_if.master   bus,
    output logic [6:0]       cur_col,
    output logic [5:0]       cur_row,
    output logic             busy
);

    localparam logic [1:0]  c_S_IDLE   = 2'd0;
    localparam logic [1:0]  c_S_CHAR   = 2'd1;
    localparam logic [1:0]  c_S_CLR    = 2'd2;

    localparam logic [12:0] c_LAST_ADR = 13'(ROWS * COLS - 1);
    localparam logic [12:0] c_COLS_M1  = 13'(COLS - 1);
    localparam logic [6:0]  c_LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  c_LAST_ROW = 6'(ROWS - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic [6:0]  r_col,   w_col_nxt;
    logic [5:0]  r_row,   w_row_nxt;
    logic [12:0] r_adr,   w_adr_nxt;
    logic [12:0] r_end,   w_end_nxt;
    logic [31:0] r_dat,   w_dat_nxt;
    logic        r_stb,   w_stb_nxt;

    logic        w_newline;
    logic [5:0]  w_nl_row;
    logic [12:0] w_cur_base;
    logic [12:0] w_nl_base;
`ifdef CONSOLE_TAB_EN
    logic [7:0]  w_tab_col;
    assign w_tab_col = ({1'b0, r_col} | 8'h07) + 8'd1;
`endif

    // Row a newline moves to: wraps to the top, the screen never scrolls
    assign w_nl_row = (r_row == c_LAST_ROW) ? 6'd0 : r_row + 6'd1;

    generate
        if (COLS == 80) begin : g_base_shift
            // row*80 = row*64 + row*16
            assign w_cur_base = ({7'd0, r_row} << 6) + ({7'd0, r_row} << 4);
            assign w_nl_base  = ({7'd0, w_nl_row} << 6) + ({7'd0, w_nl_row} << 4);
        end else begin : g_base_mul
            assign w_cur_base = {7'd0, r_row} * 13'(COLS);
            assign w_nl_base  = {7'd0, w_nl_row} * 13'(COLS);
        end
    endgenerate

    // State and datapath registers; reset launches a full-screen clear
    always_ff @(posedge clk_25mhz) begin
        if (rst_i) begin
            r_state <= c_S_CLR;
            r_col   <= 7'd0;
            r_row   <= 6'd0;
            r_adr   <= 13'd0;
            r_end   <= c_LAST_ADR;
            r_dat   <= 32'd0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_adr   <= w_adr_nxt;
            r_end   <= w_end_nxt;
            r_dat   <= w_dat_nxt;
            r_stb   <= w_stb_nxt;
        end
    end

    // Next-state logic: byte decode, bus handshake, cursor and clear sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_adr_nxt   = r_adr;
        w_end_nxt   = r_end;
        w_dat_nxt   = r_dat;
        w_stb_nxt   = r_stb;
        w_newline   = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        w_state_nxt = c_S_CHAR;
                        w_adr_nxt   = w_cur_base + {6'd0, r_col};
                        w_dat_nxt   = {24'd0, bus.in_data};
                        w_stb_nxt   = 1'b1;
                    end else begin
                        case (bus.in_data)
                            8'h0A: w_newline = 1'b1;
                            8'h0D: w_col_nxt = 7'd0;
                            8'h08: begin
                                if (r_col != 7'd0) begin
                                    w_col_nxt = r_col - 7'd1;
                                end
                            end
                            8'h0C: begin
                                w_col_nxt   = 7'd0;
                                w_row_nxt   = 6'd0;
                                w_adr_nxt   = 13'd0;
                                w_end_nxt   = c_LAST_ADR;
                                w_dat_nxt   = {24'd0, FILL};
                                w_stb_nxt   = 1'b1;
                                w_state_nxt = c_S_CLR;
                            end
`ifdef CONSOLE_TAB_EN
                            8'h09: begin
                                if (w_tab_col >= 8'(COLS)) begin
                                    w_newline = 1'b1;
                                end else begin
                                    w_col_nxt = w_tab_col[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            c_S_CHAR: begin
                if (bus.ack_i) begin
                    if (r_col == c_LAST_COL) begin
                        w_newline = 1'b1;
                    end else begin
                        w_col_nxt   = r_col + 7'd1;
                        w_stb_nxt   = 1'b0;
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_CLR: begin
                // First cycle after reset has stb low: raise it for the start address
                if (!r_stb) begin
                    w_stb_nxt = 1'b1;
                    w_dat_nxt = {24'd0, FILL};
                end else if (bus.ack_i) begin
                    if (r_adr == r_end) begin
                        w_stb_nxt   = 1'b0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_adr_nxt = r_adr + 13'd1;
                    end
                end
            end
            default: begin
                w_stb_nxt   = 1'b0;
                w_state_nxt = c_S_IDLE;
            end
        endcase

        // Newline: home column, next row, then blank that row
        if (w_newline) begin
            w_col_nxt   = 7'd0;
            w_row_nxt   = w_nl_row;
            w_adr_nxt   = w_nl_base;
            w_end_nxt   = w_nl_base + c_COLS_M1;
            w_dat_nxt   = {24'd0, FILL};
            w_stb_nxt   = 1'b1;
            w_state_nxt = c_S_CLR;
        end
    end

    // Outputs: bus signals come straight from registers, status from state
    always_comb begin
        bus.in_ready = (r_state == c_S_IDLE);
        busy         = (r_state != c_S_IDLE);
        bus.stb_o    = r_stb;
        bus.we_o     = r_stb;
        bus.adr_o    = r_adr;
        bus.dat_o    = r_dat;
        bus.sel_o    = 4'b0001;
        cur_col      = r_col;
        cur_row      = r_row;
    end

endmodule

`default_nettype wire

// File: tb/tb_text_console.sv
// ============================================================================
// Module : tb_text_console
// Brief  : Self-checking bench for text_console with a write scoreboard.
//          Build with or without CONSOLE_TAB_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_text_console;

    logic       clk_25mhz = 1'b0;
    logic       rst_i     = 1'b1;
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic       busy;

    always #20 clk_25mhz = ~clk_25mhz;

    text_console_if bus();

    text_console dut (
        .clk_25mhz (clk_25mhz),
        .rst_i     (rst_i),
        .bus       (bus),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int writes_seen  = 0;
    int ws           = 0;
    int wcnt         = 0;
    int m_col        = 0;
    int m_row        = 0;

    // Expected writes: {adr[12:0], dat[31:0]}
    logic [44:0] exp_q[$];

    // Target: acknowledges after ws wait cycles
    assign bus.ack_i = bus.stb_o && (wcnt >= ws);

    always @(posedge clk_25mhz) begin
        if (!bus.stb_o || bus.ack_i) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    // Bus monitor: scoreboard compare on each acked cycle, hold check on waits
    logic        pend = 1'b0;
    logic [12:0] p_adr;
    logic [31:0] p_dat;
    logic [44:0] e;

    always @(negedge clk_25mhz) begin
        if (rst_i) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                tests_run++;
                if (!(bus.stb_o === 1'b1 && bus.adr_o === p_adr && bus.dat_o === p_dat)) begin
                    tests_failed++;
                    $display("FAIL hold: stb=%b adr=%0d dat=%h, required stb=1 adr=%0d dat=%h",
                             bus.stb_o, bus.adr_o, bus.dat_o, p_adr, p_dat);
                end
            end
            if (bus.stb_o === 1'b1 && bus.ack_i === 1'b1) begin
                writes_seen++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL write: unexpected adr=%0d dat=%h, required no write",
                             bus.adr_o, bus.dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.adr_o, bus.dat_o, bus.sel_o, bus.we_o} !== {e, 4'b0001, 1'b1}) begin
                        tests_failed++;
                        $display("FAIL write: adr=%0d dat=%h sel=%b we=%b, required adr=%0d dat=%h sel=0001 we=1",
                                 bus.adr_o, bus.dat_o, bus.sel_o, bus.we_o, e[44:32], e[31:0]);
                    end
                end
            end
            pend  = bus.stb_o && !bus.ack_i;
            p_adr = bus.adr_o;
            p_dat = bus.dat_o;
        end
    end

    // ------------------------------------------------------------------ model
    task automatic push_clear(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({13'(first + i), 32'h0000_0020});
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row == 59) ? 0 : m_row + 1;
        push_clear(m_row * 80, 80);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int t;
        t = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({13'(m_row * 80 + m_col), {24'd0, b}});
            if (m_col == 79) model_newline();
            else             m_col++;
        end else begin
            case (b)
                8'h0A: model_newline();
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) m_col--;
                8'h0C: begin m_col = 0; m_row = 0; push_clear(0, 4800); end
                8'h09: begin
`ifdef CONSOLE_TAB_EN
                    t = (m_col | 7) + 1;
                    if (t >= 80) model_newline();
                    else         m_col = t;
`endif
                end
                default: ;
            endcase
        end
    endtask

    // --------------------------------------------------------------- drivers
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_25mhz);
        while (bus.in_ready !== 1'b1 && n < 20000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 20000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        model_byte(b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk_25mhz);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_25mhz);
            n++;
        end while (!(bus.in_ready === 1'b1 && bus.stb_o === 1'b0 && exp_q.size() == 0) && n < 20000);
        if (n >= 20000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL idle_timeout: in_ready=%b pending=%0d, required idle with 0 pending",
                     bus.in_ready, exp_q.size());
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        ws           = 0;
        rst_i        = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        tests_run++;
        if ({bus.stb_o, bus.we_o, bus.in_ready, busy, bus.adr_o, bus.dat_o, cur_col, cur_row}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 13'd0, 32'd0, 7'd0, 6'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: stb=%b we=%b rdy=%b busy=%b adr=%0d dat=%h col=%0d row=%0d, required 0 0 0 1 0 0 0 0",
                     bus.stb_o, bus.we_o, bus.in_ready, busy, bus.adr_o, bus.dat_o, cur_col, cur_row);
        end
        m_col = 0;
        m_row = 0;
        push_clear(0, 4800);
        rst_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_25mhz);
            n++;
        end while (bus.in_ready !== 1'b1 && n < 6000);
        tests_run++;
        if (n !== 4801) begin
            tests_failed++;
            $display("FAIL reset_clear_len: in_ready rose on cycle %0d, required 4801", n);
        end
        tests_run++;
        if (exp_q.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_done: pending=%0d col=%0d row=%0d, required 0 0 0",
                     exp_q.size(), cur_col, cur_row);
        end
    endtask

    task automatic test_char();
        @(negedge clk_25mhz);
        model_byte(8'h41);
        bus.in_data  = 8'h41;
        bus.in_valid = 1'b1;
        @(negedge clk_25mhz);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.stb_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL char_cycle1: rdy=%b stb=%b, required rdy=0 stb=1", bus.in_ready, bus.stb_o);
        end
        @(negedge clk_25mhz);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.stb_o !== 1'b0 || cur_col !== 7'd1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL char_cycle2: rdy=%b stb=%b col=%0d pending=%0d, required 1 0 1 0",
                     bus.in_ready, bus.stb_o, cur_col, exp_q.size());
        end
    endtask

    task automatic test_line_wrap();
        send_byte(8'h0D);
        for (int i = 0; i < 80; i++) send_byte(8'h42);
        wait_idle();
        tests_run++;
        if (cur_col !== 7'd0 || cur_row !== 6'd1) begin
            tests_failed++;
            $display("FAIL line_wrap: cursor=(%0d,%0d), required (0,1)", cur_col, cur_row);
        end
    endtask

    task automatic test_bottom_wrap();
        logic saw_stb;
        send_byte(8'h0C);
        for (int i = 0; i < 59; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte(8'h78);
        wait_idle();
        tests_run++;
        if (cur_col !== 7'd5 || cur_row !== 6'd59) begin
            tests_failed++;
            $display("FAIL bottom_pos: cursor=(%0d,%0d), required (5,59)", cur_col, cur_row);
        end
        send_byte(8'h0A);
        wait_idle();
        tests_run++;
        if (cur_col !== 7'd0 || cur_row !== 6'd0) begin
            tests_failed++;
            $display("FAIL bottom_wrap: cursor=(%0d,%0d), required (0,0)", cur_col, cur_row);
        end
        saw_stb = 1'b0;
        send_byte(8'h08);
        repeat (4) begin
            if (bus.stb_o !== 1'b0) saw_stb = 1'b1;
            @(negedge clk_25mhz);
        end
        tests_run++;
        if (saw_stb !== 1'b0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
            tests_failed++;
            $display("FAIL bs_col0: stb_seen=%b cursor=(%0d,%0d), required 0 (0,0)", saw_stb, cur_col, cur_row);
        end
        send_byte(8'h71);
        send_byte(8'h08);
        wait_idle();
        tests_run++;
        if (cur_col !== 7'd0) begin
            tests_failed++;
            $display("FAIL bs_col1: col=%0d, required 0", cur_col);
        end
    endtask

    task automatic test_wait_states();
        int w0;
        int hi;
        ws = 3;
        w0 = writes_seen;
        send_byte(8'h6B);
        hi = 0;
        while (bus.stb_o === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk_25mhz);
        end
        tests_run++;
        if (hi !== 4) begin
            tests_failed++;
            $display("FAIL ws_len: stb high %0d cycles, required 4", hi);
        end
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h7A);
        wait_idle();
        tests_run++;
        if (writes_seen - w0 !== 4) begin
            tests_failed++;
            $display("FAIL ws_count: %0d writes, required 4", writes_seen - w0);
        end
        ws = 0;
    endtask

    task automatic test_reset_mid_clr();
        int w0;
        send_byte(8'h0C);
        repeat (100) @(negedge clk_25mhz);
        @(posedge clk_25mhz);
        #1 rst_i = 1'b1;
        @(negedge clk_25mhz);
        @(negedge clk_25mhz);
        tests_run++;
        if (bus.stb_o !== 1'b0 || bus.in_ready !== 1'b0 || bus.adr_o !== 13'd0) begin
            tests_failed++;
            $display("FAIL midrst_state: stb=%b rdy=%b adr=%0d, required 0 0 0",
                     bus.stb_o, bus.in_ready, bus.adr_o);
        end
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        push_clear(0, 4800);
        w0    = writes_seen;
        rst_i = 1'b0;
        wait_idle();
        tests_run++;
        if (writes_seen - w0 !== 4800 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
            tests_failed++;
            $display("FAIL midrst_clear: %0d writes cursor=(%0d,%0d), required 4800 (0,0)",
                     writes_seen - w0, cur_col, cur_row);
        end
    endtask

    task automatic test_tab();
        int  w0;
        logic saw_stb;
        send_byte(8'h0D);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        wait_idle();
        w0      = writes_seen;
        saw_stb = 1'b0;
        send_byte(8'h09);
        repeat (3) begin
            if (bus.stb_o !== 1'b0) saw_stb = 1'b1;
            @(negedge clk_25mhz);
        end
        wait_idle();
        tests_run++;
        if (saw_stb !== 1'b0 || writes_seen !== w0 || int'(cur_col) !== m_col) begin
            tests_failed++;
            $display("FAIL tab: stb_seen=%b writes=%0d col=%0d, required 0 0 %0d",
                     saw_stb, writes_seen - w0, cur_col, m_col);
        end
`ifdef CONSOLE_TAB_EN
        tests_run++;
        if (cur_col !== 7'd8) begin
            tests_failed++;
            $display("FAIL tab_col: col=%0d, required 8", cur_col);
        end
`else
        tests_run++;
        if (cur_col !== 7'd3) begin
            tests_failed++;
            $display("FAIL tab_col: col=%0d, required 3", cur_col);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_char();
        test_line_wrap();
        test_bottom_wrap();
        test_wait_states();
        test_reset_mid_clr();
        test_tab();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
